// File: rtl/conv_core_mc.sv
// conv_core_mc
// Multi-channel FIR filter core. CHANNELS independent sample streams share one
// set of TAPS signed coefficients. Each accepted input frame pushes one sample
// per channel into that channel's delay line. The core then runs TAPS
// multiply-accumulate cycles, with all channels in parallel. It presents one
// output frame and holds it until the downstream side accepts it.
//
// Ports
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   s_valid/s_ready      input frame handshake
//   s_data               offset-binary samples, channel c at [c*DATA_BITWIDTH +: DATA_BITWIDTH]
//   m_valid/m_ready      result frame handshake
//   m_data               offset-binary filter results
//   m_pp_data            input frame that produced m_data
//   p_sel/p_ce/p_we      register bus select, access phase, write
//   p_strb, p_addr       write byte enables, word address
//   p_wdata, p_rdata     write / read data
//   p_rdy                access completes this cycle
//
// Register map
//   0 .. TAPS-1          coefficient c[i], signed, sign-extended on read
//   0x100 CTRL           bit0 enable, bits[12:8] output shift
//   0x104 STATUS         bit0 busy (RO), bit 8+ch sticky saturation (W1C)
module conv_core_mc #(
   parameter int DATA_BITWIDTH = 16,
   parameter int COEF_BITWIDTH = 16,
   parameter int TAPS          = 16,
   parameter int CHANNELS      = 2
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [DATA_BITWIDTH*CHANNELS-1:0] s_data,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [DATA_BITWIDTH*CHANNELS-1:0] m_data,
   output logic [DATA_BITWIDTH*CHANNELS-1:0] m_pp_data,
   input  logic                              p_sel,
   input  logic                              p_ce,
   input  logic                              p_we,
   input  logic [3:0]                        p_strb,
   input  logic [31:0]                       p_addr,
   input  logic [31:0]                       p_wdata,
   output logic                              p_rdy,
   output logic [31:0]                       p_rdata
);

   localparam int TAP_W   = $clog2(TAPS);
   localparam int PROD_W  = DATA_BITWIDTH + COEF_BITWIDTH;
   localparam int ACC_W   = PROD_W + TAP_W;
   localparam int FRAME_W = DATA_BITWIDTH * CHANNELS;

   localparam logic [31:0] CTRL_ADDR   = 32'h0000_0100;
   localparam logic [31:0] STATUS_ADDR = 32'h0000_0104;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_BITWIDTH+1){1'b0}}, {(DATA_BITWIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_BITWIDTH+1){1'b1}}, {(DATA_BITWIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Shift, saturate and return to offset-binary.
   // The returned MSB flags that saturation occurred.
   function automatic logic [DATA_BITWIDTH:0] out_conv(
      input logic signed [ACC_W-1:0] acc,
      input logic [4:0]              sh
   );
      logic signed [ACC_W-1:0]         shd;
      logic signed [DATA_BITWIDTH-1:0] res;
      logic                            sat;
      shd = acc >>> sh;
      if (shd > SAT_MAX) begin
         res = {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
         sat = 1'b1;
      end else if (shd < SAT_MIN) begin
         res = {1'b1, {(DATA_BITWIDTH-1){1'b0}}};
         sat = 1'b1;
      end else begin
         res = shd[DATA_BITWIDTH-1:0];
         sat = 1'b0;
      end
      return {sat, ~res[DATA_BITWIDTH-1], res[DATA_BITWIDTH-2:0]};
   endfunction

   state_t                          state_r, state_nxt_s;
   logic signed [COEF_BITWIDTH-1:0] coef_r [TAPS];
   logic signed [DATA_BITWIDTH-1:0] x_r    [CHANNELS][TAPS];
   logic signed [ACC_W-1:0]         acc_r  [CHANNELS];
   logic [TAP_W-1:0]                tap_r;
   logic                            enable_r;
   logic [4:0]                      shift_r;
   logic [CHANNELS-1:0]             sat_r;
   logic [FRAME_W-1:0]              pp_shadow_r;

   logic signed [PROD_W-1:0]        prod_s    [CHANNELS];
   logic signed [ACC_W-1:0]         acc_sum_s [CHANNELS];
   logic [DATA_BITWIDTH:0]          conv_s    [CHANNELS];
   logic [FRAME_W-1:0]              res_data_s;
   logic [CHANNELS-1:0]             sat_hit_s;
   logic [CHANNELS-1:0]             sat_clr_s;
   logic [CHANNELS-1:0]             sat_nxt_s;
   logic                            accept_s;
   logic                            last_tap_s;
   logic                            busy_s;
   logic                            stall_s;
   logic                            wr_en_s;
   logic [TAP_W-1:0]                coef_idx_s;
   logic                            coef_sel_s;
   logic                            ctrl_sel_s;
   logic                            status_sel_s;
   logic [31:0]                     byte_mask_s;
   logic [31:0]                     wdata_masked_s;
   logic [31:0]                     rd_word_s;
   logic [31:0]                     wr_merge_s;
   logic                            unused_bits_s;

   assign busy_s     = (state_r != IDLE);
   assign s_ready    = (state_r == IDLE) & enable_r;
   assign accept_s   = s_valid & s_ready;
   assign last_tap_s = (state_r == MAC) & (tap_r == TAP_W'(TAPS - 1));

   // Writes wait for IDLE so coefficients and CTRL never change mid-frame.
   assign stall_s    = p_we & busy_s;
   assign p_rdy      = p_sel & p_ce & ~stall_s;
   assign wr_en_s    = p_rdy & p_we;
   assign p_rdata    = p_rdy ? rd_word_s : 32'd0;
   assign coef_idx_s = p_addr[TAP_W-1:0];

   // Only the coefficient and CTRL fields of the merged word are stored.
   assign unused_bits_s = ^wr_merge_s;

   // Bus decode: current value of the addressed register and the byte-merged write word.
   always_comb begin
      byte_mask_s    = {{8{p_strb[3]}}, {8{p_strb[2]}}, {8{p_strb[1]}}, {8{p_strb[0]}}};
      wdata_masked_s = p_wdata & byte_mask_s;
      rd_word_s      = 32'd0;
      coef_sel_s     = 1'b0;
      ctrl_sel_s     = 1'b0;
      status_sel_s   = 1'b0;
      if (p_addr < 32'(TAPS)) begin
         coef_sel_s = 1'b1;
         rd_word_s  = {{(32-COEF_BITWIDTH){coef_r[coef_idx_s][COEF_BITWIDTH-1]}},
                       coef_r[coef_idx_s]};
      end else if (p_addr == CTRL_ADDR) begin
         ctrl_sel_s = 1'b1;
         rd_word_s  = {19'd0, shift_r, 7'd0, enable_r};
      end else if (p_addr == STATUS_ADDR) begin
         status_sel_s             = 1'b1;
         rd_word_s[0]             = busy_s;
         rd_word_s[8 +: CHANNELS] = sat_r;
      end else begin
         rd_word_s = 32'd0;
      end
      wr_merge_s = (rd_word_s & ~byte_mask_s) | wdata_masked_s;
   end

   // Per-channel MAC step and the output conversion of the running sum.
   always_comb begin
      res_data_s = {FRAME_W{1'b0}};
      sat_hit_s  = {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
         prod_s[c]    = coef_r[tap_r] * x_r[c][tap_r];
         acc_sum_s[c] = acc_r[c] + {{TAP_W{prod_s[c][PROD_W-1]}}, prod_s[c]};
         conv_s[c]    = out_conv(acc_sum_s[c], shift_r);
         res_data_s[c*DATA_BITWIDTH +: DATA_BITWIDTH] = conv_s[c][DATA_BITWIDTH-1:0];
         sat_hit_s[c] = conv_s[c][DATA_BITWIDTH];
      end
   end

   // Sticky saturation: a new saturation on the same edge as a clear wins.
   always_comb begin
      if (wr_en_s & status_sel_s) begin
         sat_clr_s = wdata_masked_s[8 +: CHANNELS];
      end else begin
         sat_clr_s = {CHANNELS{1'b0}};
      end
      if (last_tap_s) begin
         sat_nxt_s = (sat_r & ~sat_clr_s) | sat_hit_s;
      end else begin
         sat_nxt_s = sat_r & ~sat_clr_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = MAC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MAC: begin
            if (last_tap_s) begin
               state_nxt_s = OUT;
            end else begin
               state_nxt_s = MAC;
            end
         end
         OUT: begin
            if (m_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = OUT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Coefficient and CTRL registers, written through the bus with byte enables.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < TAPS; i++) begin
            coef_r[i] <= {COEF_BITWIDTH{1'b0}};
         end
         enable_r <= 1'b0;
         shift_r  <= 5'd0;
      end else if (wr_en_s) begin
         if (coef_sel_s) begin
            coef_r[coef_idx_s] <= wr_merge_s[COEF_BITWIDTH-1:0];
         end else if (ctrl_sel_s) begin
            enable_r <= wr_merge_s[0];
            shift_r  <= wr_merge_s[12:8];
         end
      end
   end

   // Datapath: delay lines, accumulators, tap counter and the output frame.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int c = 0; c < CHANNELS; c++) begin
            acc_r[c] <= {ACC_W{1'b0}};
            for (int i = 0; i < TAPS; i++) begin
               x_r[c][i] <= {DATA_BITWIDTH{1'b0}};
            end
         end
         tap_r       <= {TAP_W{1'b0}};
         pp_shadow_r <= {FRAME_W{1'b0}};
         sat_r       <= {CHANNELS{1'b0}};
         m_valid     <= 1'b0;
         m_data      <= {FRAME_W{1'b0}};
         m_pp_data   <= {FRAME_W{1'b0}};
      end else begin
         sat_r <= sat_nxt_s;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     for (int i = TAPS - 1; i > 0; i--) begin
                        x_r[c][i] <= x_r[c][i-1];
                     end
                     // Offset-binary to two's complement: invert the MSB.
                     x_r[c][0] <= {~s_data[c*DATA_BITWIDTH + DATA_BITWIDTH - 1],
                                   s_data[c*DATA_BITWIDTH +: DATA_BITWIDTH - 1]};
                     acc_r[c]  <= {ACC_W{1'b0}};
                  end
                  tap_r       <= {TAP_W{1'b0}};
                  pp_shadow_r <= s_data;
               end
            end
            MAC: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  acc_r[c] <= acc_sum_s[c];
               end
               tap_r <= tap_r + TAP_W'(1);
               // The final tap's sum goes straight to the output registers.
               if (last_tap_s) begin
                  m_valid   <= 1'b1;
                  m_data    <= res_data_s;
                  m_pp_data <= pp_shadow_r;
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
               end
            end
            default: m_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_core_mc.sv
// tb_conv_core_mc
// Directed bench for conv_core_mc with TAPS=16 and CHANNELS=2. Inputs are
// driven on the falling edge, and outputs are sampled on the falling edge.
// Every expected value below is hand-computed.
module tb_conv_core_mc;

   localparam int D    = 16;
   localparam int TAPS = 16;
   localparam int CH   = 2;

   localparam logic [31:0] CTRL   = 32'h0000_0100;
   localparam logic [31:0] STATUS = 32'h0000_0104;

   logic          clk = 1'b0;
   logic          rstn;
   logic          s_valid;
   logic          s_ready;
   logic [D*CH-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [D*CH-1:0] m_data;
   logic [D*CH-1:0] m_pp_data;
   logic          p_sel, p_ce, p_we;
   logic [3:0]    p_strb;
   logic [31:0]   p_addr, p_wdata;
   logic          p_rdy;
   logic [31:0]   p_rdata;

   int n_checks = 0;
   int n_errors = 0;

   conv_core_mc #(
      .DATA_BITWIDTH(D), .COEF_BITWIDTH(16), .TAPS(TAPS), .CHANNELS(CH)
   ) dut (
      .clk(clk), .rstn(rstn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_pp_data(m_pp_data),
      .p_sel(p_sel), .p_ce(p_ce), .p_we(p_we), .p_strb(p_strb),
      .p_addr(p_addr), .p_wdata(p_wdata), .p_rdy(p_rdy), .p_rdata(p_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output int waited);
      waited = 0;
      p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b1;
      p_addr = addr; p_wdata = data; p_strb = strb;
      #1;
      while (p_rdy !== 1'b1 && waited < 200) begin
         @(negedge clk); #1;
         waited++;
      end
      check_val("wr_rdy", {31'd0, p_rdy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
      int w;
      bus_write(addr, data, 4'hF, w);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b0; p_addr = addr; p_strb = 4'h0;
      #1;
      check_val("rd_rdy", {31'd0, p_rdy}, 32'd1);
      data = p_rdata;
      @(negedge clk);
      p_sel = 1'b0; p_ce = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] d0, input logic [15:0] d1);
      int n = 0;
      s_data = {d1, d0}; s_valid = 1'b1;
      #1;
      while (s_ready !== 1'b1 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check_val("s_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   // lat counts cycles with the accept cycle as cycle 0.
   task automatic get_result(output logic [31:0] md, output logic [31:0] mpp, output int lat);
      lat = 1;
      while (m_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_val("m_valid", {31'd0, m_valid}, 32'd1);
      md  = m_data;
      mpp = m_pp_data;
      if (m_ready) @(negedge clk);
   endtask

   task automatic frame(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [31:0] exp, output int lat);
      logic [31:0] md, mpp;
      send_frame(d0, d1);
      get_result(md, mpp, lat);
      check_val(tag, md, exp);
      check_val({tag, "_pp"}, mpp, {d1, d0});
   endtask

   initial begin
      logic [31:0] rd, md, mpp;
      logic [15:0] e0;
      int          lat, w;

      rstn = 1'b0; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b1;
      p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0; p_strb = 4'h0;
      p_addr = 32'd0; p_wdata = 32'd0;
      repeat (2) @(negedge clk);
      check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check_val("rst_s_ready", {31'd0, s_ready}, 32'd0);
      check_val("rst_m_data", m_data, 32'd0);
      check_val("rst_m_pp", m_pp_data, 32'd0);
      check_val("rst_p_rdata", p_rdata, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      bus_read(CTRL, rd);    check_val("rst_ctrl", rd, 32'd0);
      bus_read(32'd3, rd);   check_val("rst_coef3", rd, 32'd0);
      check_val("dis_s_ready", {31'd0, s_ready}, 32'd0);

      // Register access, byte strobes and sign extension
      bus_wr(CTRL, 32'h0000_0001);
      for (int i = 0; i < TAPS; i++) bus_wr(32'(i), 32'(i + 1));
      bus_write(32'd0, 32'hFFFF_ABCD, 4'b0001, w);
      bus_read(32'd0, rd);   check_val("strb_b0", rd, 32'h0000_00CD);
      bus_write(32'd0, 32'h0000_8000, 4'b0010, w);
      bus_read(32'd0, rd);   check_val("strb_b1_sext", rd, 32'hFFFF_80CD);
      bus_wr(32'd0, 32'd1);
      bus_read(32'd15, rd);  check_val("coef15", rd, 32'd16);
      bus_read(CTRL, rd);    check_val("ctrl", rd, 32'h0000_0001);
      bus_wr(32'h0000_0200, 32'hFFFF_FFFF);
      bus_read(32'h0000_0200, rd); check_val("unmapped", rd, 32'd0);
      bus_read(STATUS, rd);  check_val("status_idle", rd, 32'd0);

      // Impulse on channel 0 walks out the coefficients 1..16, then zero
      for (int k = 0; k <= TAPS; k++) begin
         e0 = (k < TAPS) ? (16'h8001 + 16'(k)) : 16'h8000;
         frame("impulse", (k == 0) ? 16'h8001 : 16'h8000, 16'h8000, {16'h8000, e0}, lat);
         if (k == 0) check_val("imp_latency", 32'(lat), 32'(TAPS + 1));
      end

      // Saturation in both directions, sticky flag and write-1-to-clear
      bus_wr(32'd0, 32'h0000_7FFF);
      for (int i = 1; i < TAPS; i++) bus_wr(32'(i), 32'd0);
      frame("sat_pos", 16'hFFFF, 16'h8000, {16'h8000, 16'hFFFF}, lat);
      bus_read(STATUS, rd);  check_val("sat_sticky", rd, 32'h0000_0100);
      frame("sat_neg", 16'h0000, 16'h8000, {16'h8000, 16'h0000}, lat);
      bus_wr(STATUS, 32'h0000_0100);
      bus_read(STATUS, rd);  check_val("sat_cleared", rd, 32'd0);

      // Output shift: 4096*x >>> 12 returns x, including a negative sample
      bus_wr(32'd0, 32'h0000_1000);
      bus_wr(CTRL, 32'h0000_0C01);
      frame("shift", 16'h8064, 16'h7F9C, {16'h7F9C, 16'h8064}, lat);
      check_val("shift_latency", 32'(lat), 32'(TAPS + 1));

      // Backpressure holds the result and blocks new frames
      m_ready = 1'b0;
      send_frame(16'h8002, 16'h8000);
      get_result(md, mpp, lat);
      check_val("bp_data", md, {16'h8000, 16'h8002});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_val("bp_valid_hold", {31'd0, m_valid}, 32'd1);
         check_val("bp_data_hold", m_data, {16'h8000, 16'h8002});
      end
      check_val("bp_pp_hold", m_pp_data, {16'h8000, 16'h8002});
      check_val("bp_s_ready", {31'd0, s_ready}, 32'd0);
      m_ready = 1'b1;
      @(negedge clk);
      check_val("bp_release_valid", {31'd0, m_valid}, 32'd0);
      check_val("bp_release_ready", {31'd0, s_ready}, 32'd1);
      frame("bp_next", 16'h8005, 16'h8000, {16'h8000, 16'h8005}, lat);

      // Bus activity during MAC: reads complete, writes wait for IDLE
      send_frame(16'h8003, 16'h8000);
      bus_read(STATUS, rd);  check_val("status_busy", rd, 32'h0000_0001);
      fork
         bus_write(32'd0, 32'h0000_2000, 4'hF, w);
         get_result(md, mpp, lat);
      join
      check_val("mac_wr_old_coef", md, {16'h8000, 16'h8003});
      check_val("mac_wr_stalled", {31'd0, w >= 10}, 32'd1);
      bus_read(32'd0, rd);   check_val("mac_wr_commit", rd, 32'h0000_2000);
      frame("mac_wr_new_coef", 16'h8003, 16'h8000, {16'h8000, 16'h8006}, lat);

      // Clearing enable mid-frame lets the frame finish, then blocks input
      send_frame(16'h8001, 16'h8000);
      fork
         bus_write(CTRL, 32'h0000_0C00, 4'hF, w);
         get_result(md, mpp, lat);
      join
      check_val("dis_frame_done", md, {16'h8000, 16'h8002});
      check_val("dis_stalled", {31'd0, w >= 10}, 32'd1);
      check_val("dis_s_ready_low", {31'd0, s_ready}, 32'd0);
      bus_read(STATUS, rd);  check_val("dis_status", rd, 32'd0);

      // Reset in the middle of MAC
      bus_wr(CTRL, 32'h0000_0C01);
      send_frame(16'h8001, 16'h8000);
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check_val("mrst_m_valid", {31'd0, m_valid}, 32'd0);
      check_val("mrst_s_ready", {31'd0, s_ready}, 32'd0);
      check_val("mrst_m_data", m_data, 32'd0);
      bus_read(CTRL, rd);    check_val("mrst_ctrl", rd, 32'd0);
      bus_read(32'd0, rd);   check_val("mrst_coef0", rd, 32'd0);
      bus_read(STATUS, rd);  check_val("mrst_status", rd, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
